// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and bus defaults
package apb_pkg;

  // Encoding matches the APB slave memory block so waveforms line up.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR       = 5;

  // A disabled timeout (limit 0) still gets a one-bit counter.
  function automatic int timer_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating wait-state counter with expiry flag
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int LIMIT = 16,
  parameter int W     = timer_width(LIMIT)
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] SAT = (LIMIT == 0) ? {W{1'b1}} : W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge pclk) begin
    if (preset || clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + W'(1);
    end
  end

  // Never expires when the limit is zero; the counter just sits saturated.
  assign expired = (LIMIT != 0) && (count == SAT);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB3 requester with wait timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int ADDR       = APB_ADDR,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR-1:0]       cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR-1:0]       paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e state;
  logic       cmd_fire;
  logic       timer_en;
  logic       timer_expired;

  // A pending response blocks new commands unless it drains this same cycle.
  assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign timer_en  = (state == ACCESS) && !pready;

  apb_wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .pclk   (pclk),
    .preset (preset),
    .clear  (cmd_fire),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // pready is checked first so a completion on the expiry cycle still succeeds.
          if (pready) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (timer_expired) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB3 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns each result on a valid/ready response channel. Sits directly upstream of the APB slave memory block: it drives psel/penable/pwrite/paddr/pwdata into that slave and consumes its pready/prdata/pslverr. Adds a wait-state timeout so a stalled slave cannot hang the requester.

## Interface
- DATA_WIDTH, 32, width of the data bus
- ADDR, 5, width of the address bus
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout
- pclk  in  1  clock; all logic on the rising edge
- preset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  pslverr sampled at completion, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR  APB address
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0. cmd_ready = !rsp_valid || rsp_ready. On accept, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable. Wait counter increments each cycle pready=0.
  - pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout=0; set rsp_valid; go to IDLE.
  - TIMEOUT≠0 and counter reaches TIMEOUT with pready still 0: drop psel/penable, rsp_err=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, go to IDLE.
- Counter: $clog2(TIMEOUT+1) bits, cleared on entry to SETUP; saturates, never wraps.
- rsp_valid clears on rsp_ready handshake; response fields hold their value while rsp_valid=1.
- pwdata/paddr/pwrite retain last values in IDLE (no return to 0).
- cmd_ready is 0 in SETUP and ACCESS; commands presented then are stalled, not dropped.

## Timing
- Reset (preset=1 at an edge): state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0. cmd_ready reads 1 the cycle after reset.
- Reset mid-transfer: abandons the transfer; psel/penable low the next cycle; no response issued.
- Zero-wait latency: accept edge N → SETUP in cycle N+1 → ACCESS in N+2 with pready=1 → rsp_valid in N+3, state IDLE. Peak throughput one transfer per 3 cycles.
- Each wait state adds one cycle. Timeout with TIMEOUT=T: rsp_valid asserts T+1 cycles after entering ACCESS.
- Simultaneous rsp_ready and cmd_valid in IDLE: both handshakes complete in the same cycle.
- pready and timeout on the same cycle: pready wins (normal completion).
- All outputs registered; no combinational path from APB inputs to APB outputs. cmd_ready is the only combinational output.

## Structure
- Shared package apb_pkg: FSM state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), matching the slave encoding; default DATA_WIDTH/ADDR constants.
- One sub-module: apb_wait_timer (counter with clear, enable, saturation and expired flag), reusable by future APB requesters.

## Test plan
- Write 0xDEADBEEF to addr 3 against slave with WAIT_PR=0 → psel high 2 cycles, penable 1 cycle; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 3 → rsp_rdata=0xDEADBEEF, rsp_err=0, same 3-cycle latency.
- Write addr 25 (slave error region) → rsp_err=1, rsp_timeout=0; a subsequent read of addr 25 also returns rsp_err=1.
- Slave holds pready=0 for 4 cycles with TIMEOUT=16 → paddr/pwrite stable throughout; rsp_valid 7 cycles after accept, no error.
- pready tied 0, TIMEOUT=4 → psel drops after 5 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command proceeds normally.
- rsp_ready held 0 with a second cmd_valid pending → cmd_ready=0 and no SETUP until rsp_ready pulses; preset asserted in ACCESS → psel=0 next cycle, rsp_valid stays 0.
